// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: drives register load enables, bubbles and PC source
// for load-use, I-cache, D-cache hazards and taken-branch redirects; counts stall cycles.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_br_taken,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             load_pc,
  output logic [1:0]       pc_sel,
  output logic             redir_capture,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_mem_wb,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {StRun, StRedirWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       fe_wait, be_wait, lu;
  logic       load_pc_c, redir_capture_c;
  logic [1:0] pc_sel_c;
  logic       load_if_id_c, load_id_ex_c, load_ex_mem_c, load_mem_wb_c;
  logic       flush_if_id_c, flush_id_ex_c, flush_mem_wb_c;

  assign fe_wait = ~imem_resp;
  assign be_wait = dmem_req & ~dmem_resp;
  assign lu      = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d         = state_q;
    load_pc_c       = 1'b1;
    pc_sel_c        = 2'd0;
    redir_capture_c = 1'b0;
    load_if_id_c    = 1'b1;
    load_id_ex_c    = 1'b1;
    load_ex_mem_c   = 1'b1;
    load_mem_wb_c   = 1'b1;
    flush_if_id_c   = 1'b0;
    flush_id_ex_c   = 1'b0;
    flush_mem_wb_c  = 1'b0;

    if (be_wait) begin
      // Freeze everything upstream of MEM; WB receives a bubble.
      load_pc_c      = 1'b0;
      load_if_id_c   = 1'b0;
      load_id_ex_c   = 1'b0;
      load_ex_mem_c  = 1'b0;
      flush_mem_wb_c = 1'b1;
    end else if ((state_q == StRun) && ex_br_taken) begin
      flush_if_id_c = 1'b1;
      flush_id_ex_c = 1'b1;
      if (imem_resp) begin
        pc_sel_c = 2'd1;
      end else begin
        // Fetch still in flight: park the target and redirect once it lands.
        load_pc_c       = 1'b0;
        redir_capture_c = 1'b1;
        state_d         = StRedirWait;
      end
    end else if (state_q == StRedirWait) begin
      flush_if_id_c = 1'b1;
      flush_id_ex_c = 1'b1;
      if (imem_resp) begin
        pc_sel_c = 2'd2;
        state_d  = StRun;
      end else begin
        load_pc_c = 1'b0;
      end
    end else if (lu) begin
      load_pc_c     = 1'b0;
      load_if_id_c  = 1'b0;
      flush_id_ex_c = 1'b1;
    end else if (fe_wait) begin
      load_pc_c     = 1'b0;
      flush_if_id_c = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((!load_pc_c || be_wait) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // All outputs are forced low while reset is asserted.
  assign load_pc       = rst_n & load_pc_c;
  assign pc_sel        = rst_n ? pc_sel_c : 2'd0;
  assign redir_capture = rst_n & redir_capture_c;
  assign load_if_id    = rst_n & load_if_id_c;
  assign load_id_ex    = rst_n & load_id_ex_c;
  assign load_ex_mem   = rst_n & load_ex_mem_c;
  assign load_mem_wb   = rst_n & load_mem_wb_c;
  assign flush_if_id   = rst_n & flush_if_id_c;
  assign flush_id_ex   = rst_n & flush_id_ex_c;
  assign flush_mem_wb  = rst_n & flush_mem_wb_c;
  assign stall_cnt     = rst_n ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random stimulus against a
// cycle-category reference model; a CNT_W=4 copy exercises counter saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_br_taken = 0;
  logic       imem_resp = 1, dmem_req = 0, dmem_resp = 0;

  logic        load_pc, redir_capture, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_mem_wb;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cnt;

  logic        load_pc4, redir_capture4, load_if_id4, load_id_ex4, load_ex_mem4, load_mem_wb4;
  logic        flush_if_id4, flush_id_ex4, flush_mem_wb4;
  logic [1:0]  pc_sel4;
  logic [3:0]  stall_cnt4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_br_taken(ex_br_taken), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .load_pc(load_pc), .pc_sel(pc_sel), .redir_capture(redir_capture),
    .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_mem_wb(flush_mem_wb), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_br_taken(ex_br_taken), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .load_pc(load_pc4), .pc_sel(pc_sel4),
    .redir_capture(redir_capture4), .load_if_id(load_if_id4), .load_id_ex(load_id_ex4),
    .load_ex_mem(load_ex_mem4), .load_mem_wb(load_mem_wb4), .flush_if_id(flush_if_id4),
    .flush_id_ex(flush_id_ex4), .flush_mem_wb(flush_mem_wb4), .stall_cnt(stall_cnt4)
  );

  // {load_pc, pc_sel, redir_capture, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
  //  flush_if_id, flush_id_ex, flush_mem_wb}
  logic [10:0] vec, vec4;
  assign vec  = {load_pc, pc_sel, redir_capture, load_if_id, load_id_ex, load_ex_mem,
                 load_mem_wb, flush_if_id, flush_id_ex, flush_mem_wb};
  assign vec4 = {load_pc4, pc_sel4, redir_capture4, load_if_id4, load_id_ex4, load_ex_mem4,
                 load_mem_wb4, flush_if_id4, flush_id_ex4, flush_mem_wb4};

  typedef enum {CNormal, CBeWait, CBrGo, CBrMiss, CRedirHold, CRedirDone, CLoadUse, CFeWait}
    cat_e;

  // Reference model state
  bit          redirect_pending = 0;
  longint      exp_cnt32 = 0;
  int          exp_cnt4 = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cat_e classify();
    bit lu_hit;
    lu_hit = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (dmem_req && !dmem_resp)  return CBeWait;
    if (redirect_pending)        return imem_resp ? CRedirDone : CRedirHold;
    if (ex_br_taken)             return imem_resp ? CBrGo : CBrMiss;
    if (lu_hit)                  return CLoadUse;
    if (!imem_resp)              return CFeWait;
    return CNormal;
  endfunction

  function automatic logic [10:0] expect_vec(input cat_e c);
    case (c)
      CBeWait:    return 11'b0_00_0_0001_001;
      CBrGo:      return 11'b1_01_0_1111_110;
      CBrMiss:    return 11'b0_00_1_1111_110;
      CRedirHold: return 11'b0_00_0_1111_110;
      CRedirDone: return 11'b1_10_0_1111_110;
      CLoadUse:   return 11'b0_00_0_0111_010;
      CFeWait:    return 11'b0_00_0_1111_100;
      default:    return 11'b1_00_0_1111_000;
    endcase
  endfunction

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step(input string tag);
    cat_e c;
    #3;
    c = classify();
    check_eq({tag, ".vec"}, 64'(vec), 64'(expect_vec(c)));
    check_eq({tag, ".vec4"}, 64'(vec4), 64'(expect_vec(c)));
    check_eq({tag, ".cnt"}, 64'(stall_cnt), 64'(exp_cnt32));
    check_eq({tag, ".cnt4"}, 64'(stall_cnt4), 64'(exp_cnt4));
    if (c != CNormal && c != CBrGo && c != CRedirDone) begin
      exp_cnt32++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    if (c == CBrMiss)    redirect_pending = 1;
    if (c == CRedirDone) redirect_pending = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; ex_br_taken = 0;
    imem_resp = 1; dmem_req = 0; dmem_resp = 0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.vec", 64'(vec), 64'd0);
    rst_n = 1;
    step("idle");

    // Load-use, then same with ex_rd=0
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step("lu");
    ex_rd = 0; id_rs1 = 0;
    step("lu_x0");
    idle();

    // D-cache wait: 3 stall cycles, then response
    dmem_req = 1;
    repeat (3) step("dwait");
    dmem_resp = 1;
    step("dresp");
    idle();

    // Branch with fetch ready
    ex_br_taken = 1;
    step("br_go");
    idle();

    // Branch during I-miss, two more miss cycles, then response
    ex_br_taken = 1; imem_resp = 0;
    step("br_miss");
    ex_br_taken = 0;
    repeat (2) step("redir_hold");
    imem_resp = 1;
    step("redir_done");
    step("after_redir");

    // Load-use and branch together: branch wins
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; ex_br_taken = 1;
    step("lu_br");
    idle();

    // Async reset in the middle of a pending redirect
    ex_br_taken = 1; imem_resp = 0;
    step("br_miss2");
    ex_br_taken = 0;
    rst_n = 0;
    #1;
    check_eq("rst_mid.vec", 64'(vec), 64'd0);
    check_eq("rst_mid.cnt", 64'(stall_cnt), 64'd0);
    redirect_pending = 0; exp_cnt32 = 0; exp_cnt4 = 0;
    idle();
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    step("post_rst");

    // 20 fetch stalls: 4-bit counter pins at 15
    imem_resp = 0;
    repeat (20) step("fewait");
    idle();
    step("sat_hold");
    check_eq("sat4", 64'(stall_cnt4), 64'd15);
    check_eq("cnt32_20", 64'(stall_cnt), 64'd20);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 99) < 35);
      ex_br_taken = ($urandom_range(0, 99) < 15);
      imem_resp   = ($urandom_range(0, 99) < 75);
      dmem_req    = ($urandom_range(0, 99) < 30);
      dmem_resp   = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
